servo_slew_pwm: RTL and testbench

- Parametrised N-channel hobby-servo PWM generator with per-channel slew limiting.
- Replaces hard-wired per-servo pulse-length registers plus a fixed sweep: a host or sequencer writes per-channel target pulse widths through a valid/ready port.
- Each channel's pulse width ramps toward its target by at most PW_STEP µs per PWM frame.
- Sits between gait/sequence logic and the servo control pins.

---
 rtl/servo_slew_pwm_if.sv | 27 ++
 rtl/servo_slew_pwm.sv | 124 ++++++++++++
 tb/tb_servo_slew_pwm.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_slew_pwm_if.sv
// Target-write port of the servo PWM block: a valid/ready channel write plus
// a one-cycle error flag for writes to a channel that does not exist.
interface servo_slew_pwm_if #(
    parameter int CHW = 2
);
    logic           wr_valid;
    logic           wr_ready;
    logic [CHW-1:0] wr_ch;
    logic [15:0]    wr_pw;
    logic           wr_err;

    modport master (
        output wr_valid,
        output wr_ch,
        output wr_pw,
        input  wr_ready,
        input  wr_err
    );

    modport slave (
        input  wr_valid,
        input  wr_ch,
        input  wr_pw,
        output wr_ready,
        output wr_err
    );
endinterface

// File: rtl/servo_slew_pwm.sv
// N-channel hobby-servo PWM generator. Each channel's pulse width slews toward
// a host-written target by at most PW_STEP us per frame, updated only at frame boundaries.
module servo_slew_pwm #(
    parameter int N_CH       = 3,
    parameter int CLK_PER_US = 50,
    parameter int FRAME_US   = 20000,
    parameter int PW_MIN     = 500,
    parameter int PW_MAX     = 2500,
    parameter int PW_CENTER  = 1500,
    parameter int PW_STEP    = 8
) (
    input  logic            CLK,
    input  logic            rst,
    servo_slew_pwm_if.slave wr,
    input  logic [N_CH-1:0] en_in,
    output logic [N_CH-1:0] servo_en,
    output logic [N_CH-1:0] CTL_PIN,
    output logic            frame_tick,
    output logic            busy
);
    localparam int USW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int FCW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    logic [USW-1:0]  us_cnt_q, us_cnt_d;
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [N_CH-1:0] servo_en_q;
    logic [N_CH-1:0] ch_busy;
    logic            us_tick;
    logic            boundary;
    logic            wr_fire;
    logic            wr_ch_ok;
    logic            wr_err_q;
    logic [15:0]     pw_clamped;

    assign us_tick    = (us_cnt_q == USW'(CLK_PER_US - 1));
    assign boundary   = us_tick && (frame_cnt_q == FCW'(FRAME_US - 1));
    assign frame_tick = boundary;

    // Refusing writes on the boundary cycle keeps target writes and slew updates disjoint.
    assign wr.wr_ready = !boundary;
    assign wr.wr_err   = wr_err_q;
    assign wr_fire     = wr.wr_valid && !boundary;
    assign wr_ch_ok    = (32'(wr.wr_ch) < N_CH);

    always_comb begin
        pw_clamped = wr.wr_pw;
        if (wr.wr_pw < 16'(PW_MIN)) begin
            pw_clamped = 16'(PW_MIN);
        end else if (wr.wr_pw > 16'(PW_MAX)) begin
            pw_clamped = 16'(PW_MAX);
        end
    end

    always_comb begin
        us_cnt_d    = us_tick ? '0 : us_cnt_q + 1'b1;
        frame_cnt_d = frame_cnt_q;
        if (us_tick) begin
            frame_cnt_d = (frame_cnt_q == FCW'(FRAME_US - 1)) ? '0 : frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            us_cnt_q    <= '0;
            frame_cnt_q <= '0;
            servo_en_q  <= '1;
            wr_err_q    <= 1'b0;
        end else begin
            us_cnt_q    <= us_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            wr_err_q    <= wr_fire && !wr_ch_ok;
            if (boundary) begin
                servo_en_q <= en_in;
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [15:0]        cur_q, cur_d;
        logic [15:0]        tgt_q, tgt_d;
        logic signed [16:0] diff;
        logic [16:0]        mag;
        logic               ctl_q;

        // Slewing is gated by the enable mask of the frame that is ending,
        // so a channel being re-enabled starts moving one frame later.
        always_comb begin
            diff  = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
            mag   = diff[16] ? 17'(-diff) : 17'(diff);
            cur_d = cur_q;
            if (boundary && servo_en_q[gi]) begin
                if (PW_STEP == 0 || mag <= 17'(PW_STEP)) begin
                    cur_d = tgt_q;
                end else if (diff[16]) begin
                    cur_d = cur_q - 16'(PW_STEP);
                end else begin
                    cur_d = cur_q + 16'(PW_STEP);
                end
            end
            tgt_d = tgt_q;
            if (wr_fire && wr_ch_ok && (32'(wr.wr_ch) == gi)) begin
                tgt_d = pw_clamped;
            end
        end

        always_ff @(posedge CLK) begin
            if (rst) begin
                cur_q <= 16'(PW_CENTER);
                tgt_q <= 16'(PW_CENTER);
                ctl_q <= 1'b0;
            end else begin
                cur_q <= cur_d;
                tgt_q <= tgt_d;
                ctl_q <= servo_en_q[gi] && (32'(frame_cnt_q) < 32'(cur_q));
            end
        end

        assign CTL_PIN[gi] = ctl_q;
        assign ch_busy[gi] = servo_en_q[gi] && (cur_q != tgt_q);
    end

    assign servo_en = servo_en_q;
    assign busy     = |ch_busy;
endmodule

// File: tb/tb_servo_slew_pwm.sv
// Bench for servo_slew_pwm: a monitor counts each channel's high cycles per frame,
// test tasks queue the expected per-frame widths and compare them frame by frame.
module tb_servo_slew_pwm;
    typedef logic [2:0][15:0] frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] en_in = 3'b111;
    logic [2:0] servo_en;
    logic [2:0] ctl_pin;
    logic       frame_tick;
    logic       busy;

    servo_slew_pwm_if #(.CHW(2)) wr_if ();

    servo_slew_pwm #(
        .N_CH(3), .CLK_PER_US(2), .FRAME_US(100), .PW_MIN(10),
        .PW_MAX(90), .PW_CENTER(50), .PW_STEP(8)
    ) dut (
        .CLK        (clk),
        .rst        (rst),
        .wr         (wr_if.slave),
        .en_in      (en_in),
        .servo_en   (servo_en),
        .CTL_PIN    (ctl_pin),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    int     frames_seen = 0;
    frame_t exp_q[$];
    frame_t meas_q[$];
    frame_t cnt;

    // Per-frame high-cycle counter; a pulse always ends before the frame does.
    always @(negedge clk) begin
        if (rst) begin
            cnt = '0;
        end else begin
            for (int c = 0; c < 3; c++) cnt[c] = cnt[c] + 16'(ctl_pin[c]);
            if (frame_tick) begin
                meas_q.push_back(cnt);
                cnt = '0;
                frames_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, output int cycles);
        int target;
        target = frames_seen + n;
        cycles = 0;
        while (frames_seen < target && cycles < n * 200 + 100) begin
            tick();
            cycles++;
        end
        if (frames_seen < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_tick_timeout got %0d frames required %0d", frames_seen, target);
        end
    endtask

    task automatic write_pw(input int ch, input int pw, output logic err);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 2'(ch);
        wr_if.wr_pw    = 16'(pw);
        for (int i = 0; i < 400 && !wr_if.wr_ready; i++) tick();
        if (!wr_if.wr_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL write_accept_timeout got wr_ready=0 required 1");
        end
        tick();
        wr_if.wr_valid = 1'b0;
        err = wr_if.wr_err;
        $display("write ch=%0d pw=%0d wr_err=%0b", ch, pw, err);
    endtask

    task automatic push_exp(input int c0, input int c1, input int c2);
        frame_t f;
        f[0] = 16'(c0);
        f[1] = 16'(c1);
        f[2] = 16'(c2);
        exp_q.push_back(f);
    endtask

    task automatic pop_frame(output frame_t e, output frame_t g, output bit ok);
        ok = (exp_q.size() > 0) && (meas_q.size() > 0);
        e = '0;
        g = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (meas_q.size() > 0) g = meas_q.pop_front();
    endtask

    task automatic test_reset();
        int cyc;
        frame_t e, g;
        bit ok;
        repeat (3) tick();
        n_chk++;
        if (ctl_pin !== 3'b000 || servo_en !== 3'b111 || busy !== 1'b0 || frame_tick !== 1'b0 ||
            wr_if.wr_err !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got ctl=%b en=%b busy=%b tick=%b err=%b rdy=%b required 000/111/0/0/0/1",
                     ctl_pin, servo_en, busy, frame_tick, wr_if.wr_err, wr_if.wr_ready);
        end
        meas_q.delete();
        exp_q.delete();
        push_exp(100, 100, 100);
        push_exp(100, 100, 100);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_frames(1, cyc);
            n_chk++;
            if (cyc != 200) begin
                n_fail++;
                $display("FAIL frame_period got %0d cycles required 200", cyc);
            end
        end
        repeat (2) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL reset_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("reset frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy got %b required 0", busy);
        end
    endtask

    task automatic test_ramp();
        int cyc;
        logic err;
        frame_t e, g;
        bit ok;
        meas_q.delete();
        push_exp(100, 100, 100);
        push_exp(116, 100, 100);
        push_exp(132, 100, 100);
        push_exp(148, 100, 100);
        push_exp(148, 100, 100);
        repeat (20) tick();
        write_pw(0, 74, err);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_busy_start got %b required 1", busy);
        end
        wait_frames(2, cyc);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_busy_mid got %b required 1", busy);
        end
        wait_frames(1, cyc);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_busy_done got %b required 0", busy);
        end
        wait_frames(2, cyc);
        repeat (5) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL ramp_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("ramp frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
    endtask

    task automatic test_clamp();
        int cyc;
        logic err;
        frame_t e, g;
        bit ok;
        meas_q.delete();
        push_exp(148, 100, 100);
        push_exp(148, 84, 116);
        push_exp(148, 68, 132);
        push_exp(148, 52, 148);
        push_exp(148, 36, 164);
        push_exp(148, 20, 180);
        write_pw(1, 5, err);
        write_pw(2, 200, err);
        wait_frames(6, cyc);
        repeat (6) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL clamp_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("clamp frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_busy got %b required 0", busy);
        end
    endtask

    task automatic test_err_boundary();
        int cyc;
        logic err;
        frame_t e, g;
        bit ok;
        meas_q.delete();
        push_exp(148, 20, 180);
        push_exp(148, 20, 180);
        push_exp(148, 20, 180);
        write_pw(3, 20, err);
        n_chk++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_pulse got %b required 1", err);
        end
        tick();
        n_chk++;
        if (wr_if.wr_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_clear got err=%b busy=%b required 0/0", wr_if.wr_err, busy);
        end
        wait_frames(1, cyc);
        for (int i = 0; i < 300 && !frame_tick; i++) tick();
        n_chk++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_search got frame_tick=%b required 1", frame_tick);
        end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 2'd0;
        wr_if.wr_pw    = 16'd30;
        n_chk++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_on_boundary got %b required 0", wr_if.wr_ready);
        end
        tick();
        n_chk++;
        if (wr_if.wr_ready !== 1'b1 || busy !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL after_boundary got rdy=%b busy=%b tick=%b required 1/0/0", wr_if.wr_ready, busy, frame_tick);
        end
        tick();
        wr_if.wr_valid = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_write_landed got busy=%b required 1", busy);
        end
        $display("held write ch=0 pw=30 accepted after boundary");
        wait_frames(1, cyc);
        repeat (3) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL err_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("err frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
    endtask

    task automatic test_enable();
        int cyc;
        logic err;
        frame_t e, g;
        bit ok;
        meas_q.delete();
        push_exp(132, 20, 180);
        push_exp(116, 0, 180);
        push_exp(100, 0, 180);
        push_exp(84, 20, 180);
        push_exp(68, 36, 180);
        push_exp(60, 52, 180);
        en_in = 3'b101;
        wait_frames(1, cyc);
        n_chk++;
        if (servo_en !== 3'b101) begin
            n_fail++;
            $display("FAIL servo_en_masked got %b required 101", servo_en);
        end
        repeat (4) tick();
        n_chk++;
        if (ctl_pin !== 3'b101) begin
            n_fail++;
            $display("FAIL disabled_pin got %b required 101", ctl_pin);
        end
        write_pw(1, 90, err);
        wait_frames(1, cyc);
        en_in = 3'b111;
        wait_frames(4, cyc);
        n_chk++;
        if (servo_en !== 3'b111 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable got en=%b busy=%b required 111/1", servo_en, busy);
        end
        repeat (6) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL enable_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("enable frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        frame_t e, g;
        bit ok;
        repeat (50) tick();
        n_chk++;
        if (ctl_pin !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_pulse got %b required 111", ctl_pin);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (ctl_pin !== 3'b000 || busy !== 1'b0 || servo_en !== 3'b111 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got ctl=%b busy=%b en=%b tick=%b required 000/0/111/0", ctl_pin, busy, servo_en, frame_tick);
        end
        repeat (2) tick();
        meas_q.delete();
        push_exp(100, 100, 100);
        push_exp(100, 100, 100);
        rst = 1'b0;
        wait_frames(1, cyc);
        n_chk++;
        if (cyc != 200) begin
            n_fail++;
            $display("FAIL post_reset_period got %0d cycles required 200", cyc);
        end
        wait_frames(1, cyc);
        repeat (2) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL post_reset_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("post-reset frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        frame_t e, g;
        bit ok;
        meas_q.delete();
        push_exp(100, 100, 100);
        push_exp(84, 100, 100);
        push_exp(68, 100, 100);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 2'd0;
        wr_if.wr_pw    = 16'd60;
        tick();
        wr_if.wr_pw    = 16'd20;
        tick();
        wr_if.wr_valid = 1'b0;
        $display("back-to-back writes ch=0 pw=60 then pw=20");
        n_chk++;
        if (wr_if.wr_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_status got err=%b busy=%b required 0/1", wr_if.wr_err, busy);
        end
        wait_frames(3, cyc);
        repeat (3) begin
            pop_frame(e, g, ok);
            n_chk++;
            if (!ok || g !== e) begin
                n_fail++;
                $display("FAIL b2b_frame got %0d/%0d/%0d required %0d/%0d/%0d", g[0], g[1], g[2], e[0], e[1], e[2]);
            end else $display("b2b frame ch0/ch1/ch2 = %0d/%0d/%0d cycles", g[0], g[1], g[2]);
        end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_ch    = 2'd0;
        wr_if.wr_pw    = 16'd0;
        test_reset();
        test_ramp();
        test_clamp();
        test_err_boundary();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
